// File: rtl/mem_access_unit_pkg.sv
// ---- mem_access_unit_pkg : shared types and defaults for the memory access unit (rev 1.0) ----
`default_nettype none

package mem_access_unit_pkg;

  localparam int ADDR_W_DEF  = 9;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;
  localparam int CNT_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  function automatic logic is_wait(input state_e s);
    return (s == ST_RD_WAIT) || (s == ST_WR_WAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_unit_wait_counter.sv
// ---- mem_access_unit_wait_counter : wait-cycle counter with clear, enable, terminal count (rev 1.0) ----
`default_nettype none

module mem_access_unit_wait_counter
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // tc fires in the TIMEOUT_CYC-th enabled cycle, i.e. the last wait cycle allowed.
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---- mem_access_unit : MAR/MDR owner and RAM handshake FSM with stall generation (rev 1.0) ----
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              write_mem,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] MDR_data,
  output logic              stall,
  output logic              mem_err,
  output logic              proto_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                armed_q, armed_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                mem_err_q, mem_err_d;
  logic                proto_err_q, proto_err_d;

  logic rd_req, wr_req, in_idle, in_wait, start_rd, start_wr, tmo_tc;

  assign rd_req   = MDRin && Read;
  assign wr_req   = write_mem;
  assign in_idle  = (state_q == ST_IDLE);
  assign in_wait  = is_wait(state_q);
  assign start_rd = in_idle && rd_req && !armed_q;
  assign start_wr = in_idle && wr_req && !armed_q && !rd_req;

  mem_access_unit_wait_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (!in_wait),
    .en   (in_wait),
    .tc   (tmo_tc)
  );

  always_comb begin
    state_d     = state_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    armed_d     = armed_q;
    rd_en_d     = rd_en_q;
    wr_en_d     = wr_en_q;
    mem_err_d   = mem_err_q;
    proto_err_d = proto_err_q;

    case (state_q)
      ST_IDLE: begin
        if (MARin)          mar_d = BusMuxOut[ADDR_W-1:0];
        if (MDRin && !Read) mdr_d = BusMuxOut;
        if (start_rd) begin
          state_d = ST_RD_WAIT;
          rd_en_d = 1'b1;
          if (wr_req) proto_err_d = 1'b1;
        end else if (start_wr) begin
          state_d = ST_WR_WAIT;
          wr_en_d = 1'b1;
        end
        // The control unit may still hold the finished request; wait for release.
        if (armed_q && !rd_req && !wr_req) armed_d = 1'b0;
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        if (mem_ack || tmo_tc) begin
          state_d = ST_DONE;
          rd_en_d = 1'b0;
          wr_en_d = 1'b0;
          armed_d = 1'b1;
          if (mem_ack && (state_q == ST_RD_WAIT)) mdr_d = mem_rdata;
          if (!mem_ack) mem_err_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!in_idle && (MARin || (MDRin && !Read))) proto_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mar_q       <= '0;
      mdr_q       <= '0;
      armed_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      mem_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      armed_q     <= armed_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      mem_err_q   <= mem_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Stall covers the request cycle combinationally so the control FSM never advances early.
  assign stall     = reset && (in_wait || start_rd || start_wr);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign MDR_data  = mdr_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign mem_err   = mem_err_q;
  assign proto_err = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---- tb_mem_access_unit : scoreboard bench for mem_access_unit (rev 1.0) ----
`default_nettype none

module tb_mem_access_unit;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] BusMuxOut;
  logic          MARin, MDRin, Read, write_mem, mem_ack;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, MDR_data;
  logic          mem_rd_en, mem_wr_en, stall, mem_err, proto_err;

  mem_access_unit #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset(reset), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
    .Read(Read), .write_mem(write_mem), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .MDR_data(MDR_data), .stall(stall), .mem_err(mem_err),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            stall_cyc;
    int            strb_cyc;
    logic [DW-1:0] mdr;
    bit            merr;
    bit            perr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: per-strobe address/data checks, and a full compare when stall falls.
  int stall_cnt = 0;
  int strb_cnt  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      stall_cnt = 0;
      strb_cnt  = 0;
    end else begin
      if (mem_rd_en || mem_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {62'd0, mem_wr_en, mem_rd_en}, 64'd0);
        end else begin
          chk("strobe_kind", {62'd0, mem_wr_en, mem_rd_en},
              exp_q[0].is_wr ? 64'd2 : 64'd1);
          chk("mem_addr", 64'(mem_addr), 64'(exp_q[0].addr));
          if (exp_q[0].is_wr) chk("mem_wdata", 64'(mem_wdata), 64'(exp_q[0].wdata));
          strb_cnt++;
        end
      end
      if (stall) begin
        stall_cnt++;
      end else if (stall_cnt > 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", 64'(stall_cnt), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("stall_cycles",  64'(stall_cnt), 64'(e.stall_cyc));
          chk("strobe_cycles", 64'(strb_cnt),  64'(e.strb_cyc));
          chk("MDR_data",      64'(MDR_data),  64'(e.mdr));
          chk("mem_err",       64'(mem_err),   64'(e.merr));
          chk("proto_err",     64'(proto_err), 64'(e.perr));
        end
        stall_cnt = 0;
        strb_cnt  = 0;
      end
    end
  end

  task automatic push(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int sc, input int bc, input logic [DW-1:0] mdr,
                      input bit me, input bit pe);
    exp_t e;
    e.is_wr = is_wr; e.addr = a; e.wdata = wd; e.stall_cyc = sc; e.strb_cyc = bc;
    e.mdr = mdr; e.merr = me; e.perr = pe;
    exp_q.push_back(e);
  endtask

  task automatic load_mar(input logic [DW-1:0] v);
    @(posedge clk); #1; BusMuxOut = v; MARin = 1'b1;
    @(posedge clk); #1; MARin = 1'b0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    @(posedge clk); #1; BusMuxOut = v; MDRin = 1'b1; Read = 1'b0;
    @(posedge clk); #1; MDRin = 1'b0;
  endtask

  // ack_at = wait cycle carrying mem_ack (0 = never); request held through DONE and one IDLE cycle.
  task automatic do_access(input bit is_rd, input bit both, input int ack_at,
                           input logic [DW-1:0] rdata, input bit mar_poke);
    int n;
    n = (ack_at == 0) ? TMO : ack_at;
    @(posedge clk); #1;
    MDRin = is_rd; Read = is_rd; write_mem = !is_rd || both;
    for (int w = 1; w <= n; w++) begin
      @(posedge clk); #1;
      mem_ack   = (w == ack_at);
      mem_rdata = (w == ack_at) ? rdata : 32'h0;
      MARin     = mar_poke && (w == 1);
      if (mar_poke && (w == 1)) BusMuxOut = 32'h0000_0042;
    end
    @(posedge clk); #1; mem_ack = 1'b0; MARin = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; MDRin = 1'b0; Read = 1'b0; write_mem = 1'b0;
  endtask

  initial begin
    reset = 1'b0; BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0; Read = 1'b0;
    write_mem = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    @(negedge clk);
    chk("rst_MDR",   64'(MDR_data), 64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    chk("rst_strb",  {62'd0, mem_wr_en, mem_rd_en}, 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flags", {62'd0, mem_err, proto_err}, 64'd0);
    @(posedge clk); #1; reset = 1'b1;

    // 1: asynchronous reset in the middle of a read wait
    load_mdr(32'hAAAA_5555);
    push(1'b0, '0, '0, 0, 0, '0, 1'b0, 1'b0);
    @(posedge clk); #1; MDRin = 1'b1; Read = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("midrst_rd_en", 64'(mem_rd_en), 64'd0);
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_MDR",   64'(MDR_data), 64'd0);
    @(posedge clk); #1; MDRin = 1'b0; Read = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {62'd0, stall, mem_rd_en}, 64'd0);

    // 2: read from address 5, ack in the second wait cycle
    load_mar(32'h0000_0005);
    push(1'b0, 9'h005, '0, 3, 2, 32'h1234_5678, 1'b0, 1'b0);
    do_access(1'b1, 1'b0, 2, 32'h1234_5678, 1'b0);

    // 3: write 0xDEADBEEF to 0x1FF, immediate ack, write_mem held afterwards
    load_mdr(32'hDEAD_BEEF);
    load_mar(32'h0000_01FF);
    push(1'b1, 9'h1FF, 32'hDEAD_BEEF, 2, 1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_access(1'b0, 1'b0, 1, '0, 1'b0);

    // 6: MARin pulse during the write wait
    push(1'b1, 9'h1FF, 32'hDEAD_BEEF, 4, 3, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_access(1'b0, 1'b0, 3, '0, 1'b1);

    // 4: read with no ack times out after TMO wait cycles
    push(1'b0, 9'h1FF, '0, TMO + 1, TMO, 32'hDEAD_BEEF, 1'b1, 1'b1);
    do_access(1'b1, 1'b0, 0, '0, 1'b0);
    @(negedge clk);
    chk("mem_err_sticky", 64'(mem_err), 64'd1);

    @(posedge clk); #1; reset = 1'b0;
    #1;
    chk("rst2_flags", {62'd0, mem_err, proto_err}, 64'd0);
    @(posedge clk); #1; reset = 1'b1;

    // 5: simultaneous read and write request: read wins, proto_err set
    load_mar(32'h0000_00AB);
    push(1'b0, 9'h0AB, '0, 2, 1, 32'h0BAD_F00D, 1'b0, 1'b1);
    do_access(1'b1, 1'b1, 1, 32'h0BAD_F00D, 1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
